// File: rtl/flash_resp_framer_pkg.sv
`default_nettype none
// ============================================================================
// Package : flash_resp_framer_pkg
// Shared states and byte constants for the flash response framer.
// Revision: 1.0
// ============================================================================
package flash_resp_framer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        TYPE = 3'd2,
        LEN  = 3'd3,
        PAY  = 3'd4,
        CSUM = 3'd5
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] PAD_BYTE         = 8'hFF;
    localparam logic [7:0] STATUS_LEN       = 8'd2;

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : resp_fifo
// Synchronous show-ahead byte FIFO; dout always shows the oldest entry.
// Revision: 1.0
// ============================================================================
module resp_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flash_resp_framer.sv
`default_nettype none
// ============================================================================
// Module  : flash_resp_framer
// Frames flash read data or status into HDR/TYPE/LEN/payload/CSUM bytes.
// Revision: 1.0
// ============================================================================
module flash_resp_framer
    import flash_resp_framer_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resp_start,
    input  logic [4:0]  resp_type,
    input  logic [7:0]  resp_len,
    input  logic        resp_is_status,
    input  logic [15:0] status_reg,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        err_ovf,
    output logic        err_tmo
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [4:0]         type_q, type_d;
    logic [7:0]         len_q, len_d;
    logic               is_status_q, is_status_d;
    logic [15:0]        status_q, status_d;
    logic [7:0]         rem_q, rem_d;
    logic [7:0]         csum_q, csum_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               frame_done_q, frame_done_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_tmo_q, err_tmo_d;

    logic               w_xfer;
    logic [7:0]         w_csum_next;
    logic               w_fifo_pop;
    logic [7:0]         w_fifo_dout;
    logic               w_fifo_empty;
    logic               w_fifo_full;

    resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (din_valid),
        .din   (din),
        .pop   (w_fifo_pop),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign w_xfer      = tx_valid_q && tx_ready;
    assign w_csum_next = csum_q + tx_data_q;

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        type_d       = type_q;
        len_d        = len_q;
        is_status_d  = is_status_q;
        status_d     = status_q;
        rem_d        = rem_q;
        csum_d       = csum_q;
        tmo_d        = tmo_q;
        frame_done_d = 1'b0;
        err_ovf_d    = err_ovf_q || (din_valid && w_fifo_full);
        err_tmo_d    = err_tmo_q;
        w_fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (resp_start) begin
                    state_d     = HDR;
                    tx_data_d   = HDR_BYTE;
                    tx_valid_d  = 1'b1;
                    type_d      = resp_type;
                    len_d       = resp_is_status ? STATUS_LEN : resp_len;
                    is_status_d = resp_is_status;
                    status_d    = status_reg;
                    csum_d      = 8'd0;
                    tmo_d       = '0;
                end
            end
            HDR: begin
                if (w_xfer) begin
                    state_d   = TYPE;
                    tx_data_d = {3'b000, type_q};
                end
            end
            TYPE: begin
                if (w_xfer) begin
                    state_d   = LEN;
                    tx_data_d = len_q;
                    csum_d    = w_csum_next;
                    rem_d     = len_q;
                end
            end
            LEN: begin
                if (w_xfer) begin
                    csum_d = w_csum_next;
                    tmo_d  = '0;
                    if (len_q == 8'd0) begin
                        state_d   = CSUM;
                        tx_data_d = w_csum_next;
                    end else begin
                        state_d = PAY;
                        if (is_status_q) begin
                            tx_data_d = status_q[15:8];
                        end else if (!w_fifo_empty) begin
                            tx_data_d  = w_fifo_dout;
                            w_fifo_pop = 1'b1;
                        end else begin
                            tx_valid_d = 1'b0;
                        end
                    end
                end
            end
            PAY: begin
                if (w_xfer) begin
                    csum_d = w_csum_next;
                    rem_d  = rem_q - 8'd1;
                    tmo_d  = '0;
                    if (rem_q == 8'd1) begin
                        state_d   = CSUM;
                        tx_data_d = w_csum_next;
                    end else if (is_status_q) begin
                        tx_data_d = status_q[7:0];
                    end else if (!w_fifo_empty) begin
                        tx_data_d  = w_fifo_dout;
                        w_fifo_pop = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end else if (!tx_valid_q) begin
                    // Output slot is empty: waiting on flash data for a data frame.
                    if (!w_fifo_empty) begin
                        tx_data_d  = w_fifo_dout;
                        tx_valid_d = 1'b1;
                        w_fifo_pop = 1'b1;
                        tmo_d      = '0;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        tx_data_d  = PAD_BYTE;
                        tx_valid_d = 1'b1;
                        err_tmo_d  = 1'b1;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    state_d      = IDLE;
                    tx_valid_d   = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            type_q       <= 5'd0;
            len_q        <= 8'd0;
            is_status_q  <= 1'b0;
            status_q     <= 16'd0;
            rem_q        <= 8'd0;
            csum_q       <= 8'd0;
            tmo_q        <= '0;
            frame_done_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            type_q       <= type_d;
            len_q        <= len_d;
            is_status_q  <= is_status_d;
            status_q     <= status_d;
            rem_q        <= rem_d;
            csum_q       <= csum_d;
            tmo_q        <= tmo_d;
            frame_done_q <= frame_done_d;
            err_ovf_q    <= err_ovf_d;
            err_tmo_q    <= err_tmo_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign err_ovf    = err_ovf_q;
    assign err_tmo    = err_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_resp_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_flash_resp_framer
// Randomized self-checking bench with a queue-based frame reference model.
// Revision: 1.0
// ============================================================================
module tb_flash_resp_framer;
    localparam int DEPTH = 16;
    localparam int TMO   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resp_start = 1'b0;
    logic [4:0]  resp_type = 5'd0;
    logic [7:0]  resp_len = 8'd0;
    logic        resp_is_status = 1'b0;
    logic [15:0] status_reg = 16'd0;
    logic [7:0]  din = 8'd0;
    logic        din_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        err_ovf;
    logic        err_tmo;

    flash_resp_framer #(
        .FIFO_DEPTH  (DEPTH),
        .HDR_BYTE    (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .resp_start     (resp_start),
        .resp_type      (resp_type),
        .resp_len       (resp_len),
        .resp_is_status (resp_is_status),
        .status_reg     (status_reg),
        .din            (din),
        .din_valid      (din_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_ovf        (err_ovf),
        .err_tmo        (err_tmo)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] mfifo[$];
    bit         exp_ovf = 0;
    bit         exp_tmo = 0;
    int         stall_errs;
    int         done_lat;
    bit         done_seen;
    logic       busy_at_done;

    // Reference: FIFO occupancy as a queue; missing payload bytes become pads.
    task automatic push_byte(input logic [7:0] b);
        din = b;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        if (mfifo.size() < DEPTH) mfifo.push_back(b);
        else exp_ovf = 1;
    endtask

    task automatic build_exp(input logic [4:0] t, input logic [7:0] l,
                             input bit st, input logic [15:0] sr);
        logic [7:0] len;
        logic [7:0] sum;
        logic [7:0] b;
        exp_q.delete();
        len = st ? 8'd2 : l;
        exp_q.push_back(8'hA5);
        exp_q.push_back({3'b000, t});
        exp_q.push_back(len);
        sum = {3'b000, t} + len;
        for (int i = 0; i < int'(len); i++) begin
            if (st) b = (i == 0) ? sr[15:8] : sr[7:0];
            else if (mfifo.size() > 0) b = mfifo.pop_front();
            else begin
                b = 8'hFF;
                exp_tmo = 1;
            end
            exp_q.push_back(b);
            sum = sum + b;
        end
        exp_q.push_back(sum);
    endtask

    task automatic start_frame(input logic [4:0] t, input logic [7:0] l,
                               input bit st, input logic [15:0] sr);
        resp_type = t;
        resp_len = l;
        resp_is_status = st;
        status_reg = sr;
        resp_start = 1'b1;
        @(posedge clk); #1;
        resp_start = 1'b0;
        resp_type = 5'($urandom);
        resp_len = 8'($urandom);
        resp_is_status = 1'($urandom);
        status_reg = 16'($urandom);
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random ready
    task automatic collect(input int mode, input bit glitch);
        int         last_x;
        bit         pv;
        bit         pr;
        logic [7:0] pd;
        got.delete();
        stall_errs = 0;
        done_seen = 0;
        done_lat = -1;
        busy_at_done = 1'bx;
        last_x = -10;
        pv = 0;
        pr = 0;
        pd = 8'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (frame_done === 1'b1) begin
                done_seen = 1;
                done_lat = cyc - last_x;
                busy_at_done = busy;
                break;
            end
            if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) stall_errs++;
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 3 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            resp_start = glitch && (cyc == 4);
            if (resp_start) begin
                resp_type = 5'h1F;
                resp_len = 8'd9;
                resp_is_status = 1'b1;
                status_reg = 16'hDEAD;
            end
            if (tx_valid === 1'b1 && tx_ready) begin
                got.push_back(tx_data);
                last_x = cyc;
            end
            pv = tx_valid;
            pr = tx_ready;
            pd = tx_data;
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        resp_start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({tx_valid, busy, frame_done, err_ovf, err_tmo} !== 5'b0) $display("FAIL reset_outputs: got %b required 00000", {tx_valid, busy, frame_done, err_ovf, err_tmo});
        else n_pass++;
        n_checks++;
        if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h required 00", tx_data);
        else n_pass++;
    endtask

    task automatic test_status();
        build_exp(5'h05, 8'd0, 1'b1, 16'h1234);
        start_frame(5'h05, 8'd0, 1'b1, 16'h1234);
        collect(0, 1'b0);
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL status_len: got %0d bytes required %0d", got.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) $display("FAIL status_byte%0d: got %h required %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (!done_seen || done_lat !== 1) $display("FAIL status_done: seen %0d latency %0d required 1", done_seen, done_lat);
        else n_pass++;
        n_checks++;
        if (busy_at_done !== 1'b0) $display("FAIL status_busy: got %b required 0", busy_at_done);
        else n_pass++;
    endtask

    task automatic test_data(input int mode, input bit glitch, input string name);
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        build_exp(5'h03, 8'd4, 1'b0, 16'h0);
        start_frame(5'h03, 8'd4, 1'b0, 16'h0);
        collect(mode, glitch);
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL %s_len: got %0d bytes required %0d", name, got.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) $display("FAIL %s_byte%0d: got %h required %h", name, i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (stall_errs !== 0 || !done_seen) $display("FAIL %s_stall: unstable %0d done %0d required 0/1", name, stall_errs, done_seen);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0]  t;
        logic [7:0]  l;
        logic [15:0] sr;
        bit          st;
        int          k;
        int          bad;
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(0, DEPTH - mfifo.size());
            for (int j = 0; j < k; j++) push_byte(8'($urandom));
            st = ($urandom_range(0, 3) == 0);
            t = 5'($urandom);
            sr = 16'($urandom);
            l = 8'($urandom_range(0, mfifo.size()));
            if (it == 0) begin
                st = 0;
                l = 8'd0;
            end
            if (it == 11) begin
                st = 0;
                l = 8'(mfifo.size());
            end
            build_exp(t, l, st, sr);
            start_frame(t, st ? 8'($urandom) : l, st, sr);
            collect(2, 1'b0);
            bad = (got.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < exp_q.size() && i < got.size(); i++)
                if (got[i] !== exp_q[i]) bad++;
            n_checks++;
            if (bad != 0 || stall_errs != 0 || done_lat != 1) $display("FAIL random_frame%0d: got %0d bytes %0d wrong stall %0d lat %0d required %0d bytes 0 wrong", it, got.size(), bad, stall_errs, done_lat, exp_q.size());
            else n_pass++;
        end
        n_checks++;
        if ({err_ovf, err_tmo} !== {exp_ovf, exp_tmo}) $display("FAIL random_flags: got %b%b required %b%b", err_ovf, err_tmo, exp_ovf, exp_tmo);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'(8'h40 + i));
        n_checks++;
        if (err_ovf !== 1'b1 || exp_ovf !== 1'b1) $display("FAIL ovf_flag: got %b required 1", err_ovf);
        else n_pass++;
        build_exp(5'h0A, 8'd16, 1'b0, 16'h0);
        start_frame(5'h0A, 8'd16, 1'b0, 16'h0);
        collect(2, 1'b0);
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL ovf_len: got %0d bytes required %0d", got.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) $display("FAIL ovf_byte%0d: got %h required %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [4:0] t;
        t = 5'($urandom);
        push_byte(8'hAA);
        build_exp(t, 8'd2, 1'b0, 16'h0);
        start_frame(t, 8'd2, 1'b0, 16'h0);
        collect(0, 1'b0);
        n_checks++;
        if (got.size() !== 6) $display("FAIL tmo_len: got %0d bytes required 6", got.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) $display("FAIL tmo_byte%0d: got %h required %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (err_tmo !== 1'b1 || exp_tmo !== 1'b1) $display("FAIL tmo_flag: got %b required 1", err_tmo);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) push_byte(8'($urandom));
        start_frame(5'h11, 8'd8, 1'b0, 16'h0);
        tx_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mfifo.delete();
        exp_ovf = 0;
        exp_tmo = 0;
        n_checks++;
        if ({tx_valid, busy, err_ovf, err_tmo} !== 4'b0) $display("FAIL midrst_state: got %b required 0000", {tx_valid, busy, err_ovf, err_tmo});
        else n_pass++;
        for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
        build_exp(5'h07, 8'd3, 1'b0, 16'h0);
        start_frame(5'h07, 8'd3, 1'b0, 16'h0);
        collect(0, 1'b0);
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL midrst_len: got %0d bytes required %0d", got.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) $display("FAIL midrst_byte%0d: got %h required %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_status();
        test_data(0, 1'b0, "data");
        test_data(1, 1'b0, "bp");
        test_data(2, 1'b1, "busystart");
        test_random();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
